// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 16-bit data memory.
// Each accepted request costs one ACCESS cycle; the response follows one cycle later.
module dmem_arbiter #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic        a_err,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [15:0] b_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [16:0] WORD_LIMIT = 17'(MEM_WORDS);

    state_t      state;
    logic        pref_b;
    logic        id_q;
    logic        we_q;
    logic        oor_q;

    logic        grant_a;
    logic        grant_b;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_oor;

    // Grant must be visible in the same cycle the request is sampled, so it is
    // decoded from the registered state and the live requests.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && state == IDLE) begin
            if (a_req && (!b_req || !pref_b)) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_gnt = grant_a;
    assign b_gnt = grant_b;

    always_comb begin
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_oor   = {2'b00, sel_addr[15:1]} >= WORD_LIMIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pref_b    <= 1'b0;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            a_rvalid  <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= 16'h0000;
            b_rvalid  <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= 16'h0000;
        end else begin
            a_rvalid  <= 1'b0;
            a_err     <= 1'b0;
            b_rvalid  <= 1'b0;
            b_err     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;

            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state     <= ACCESS;
                        id_q      <= grant_b;
                        pref_b    <= grant_a;
                        we_q      <= sel_we;
                        oor_q     <= sel_oor;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_write <= sel_we && !sel_oor;
                        mem_read  <= !sel_we && !sel_oor;
                    end
                end

                ACCESS: begin
                    // Out-of-range and write responses leave the requester's rdata untouched.
                    state <= IDLE;
                    if (id_q) begin
                        b_rvalid <= 1'b1;
                        b_err    <= oor_q;
                        if (!we_q && !oor_q) begin
                            b_rdata <= mem_rdata;
                        end
                    end else begin
                        a_rvalid <= 1'b1;
                        a_err    <= oor_q;
                        if (!we_q && !oor_q) begin
                            a_rdata <= mem_rdata;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected transactions at issue,
// a negedge monitor follows each grant through ACCESS and response and compares.
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem_model [0:255];

    typedef struct {
        bit          id;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          err;
        logic [15:0] rdata;
        bit          resp;
    } txn_t;

    txn_t exp_q[$];
    txn_t p1, p2, t_mon;
    bit   p1v = 1'b0;
    bit   p2v = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural data memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_addr[8:1]] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem_model[mem_addr[8:1]] : 16'h0000;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Follows every grant: next cycle is its ACCESS, the one after its response.
    always @(negedge clk) begin
        if (mon_en) begin
            if (p1v) begin
                checkOutput("acc_mem_write", 16'(mem_write), 16'(p1.we && !p1.err));
                checkOutput("acc_mem_read",  16'(mem_read),  16'(!p1.we && !p1.err));
                checkOutput("acc_mem_addr",  mem_addr,  p1.addr);
                checkOutput("acc_mem_wdata", mem_wdata, p1.wdata);
            end else begin
                checkOutput("idle_mem_ctl",   {14'b0, mem_read, mem_write}, 16'h0000);
                checkOutput("idle_mem_addr",  mem_addr,  16'h0000);
                checkOutput("idle_mem_wdata", mem_wdata, 16'h0000);
            end

            if (p2v && p2.resp) begin
                if (p2.id) begin
                    checkOutput("b_rvalid", 16'(b_rvalid), 16'd1);
                    checkOutput("a_rvalid_quiet", 16'(a_rvalid), 16'd0);
                    checkOutput("b_err", 16'(b_err), 16'(p2.err));
                    checkOutput("b_rdata", b_rdata, p2.rdata);
                end else begin
                    checkOutput("a_rvalid", 16'(a_rvalid), 16'd1);
                    checkOutput("b_rvalid_quiet", 16'(b_rvalid), 16'd0);
                    checkOutput("a_err", 16'(a_err), 16'(p2.err));
                    checkOutput("a_rdata", a_rdata, p2.rdata);
                end
            end else begin
                checkOutput("rvalid_idle", {14'b0, a_rvalid, b_rvalid}, 16'h0000);
            end

            checkOutput("err_without_rvalid", {14'b0, a_err & ~a_rvalid, b_err & ~b_rvalid}, 16'h0000);
            checkOutput("gnt_exclusive", 16'(a_gnt & b_gnt), 16'd0);

            p2  = p1;
            p2v = p1v;
            p1v = 1'b0;
            if (a_gnt || b_gnt) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_gnt: got a=%0b b=%0b expected none", a_gnt, b_gnt);
                end else begin
                    t_mon = exp_q.pop_front();
                    checkOutput("gnt_id", 16'(b_gnt), 16'(t_mon.id));
                    p1  = t_mon;
                    p1v = 1'b1;
                end
            end
        end
    end

    task automatic pushTxn(input bit id, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                           input bit err, input logic [15:0] rdata, input bit resp);
        txn_t t;
        t.id = id; t.we = we; t.addr = addr; t.wdata = wdata;
        t.err = err; t.rdata = rdata; t.resp = resp;
        exp_q.push_back(t);
    endtask

    task automatic driveReq(input bit id, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        if (id) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic waitGnt(input bit id);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = id ? b_gnt : a_gnt;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL gnt_timeout: got no gnt for requester %0d expected one within 50 cycles", id);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit id, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit err, input logic [15:0] rdata);
        pushTxn(id, we, addr, wdata, err, rdata, 1'b1);
        driveReq(id, we, addr, wdata);
        waitGnt(id);
        @(posedge clk);
        #1;
        if (id) b_req = 1'b0; else a_req = 1'b0;
        idle(4);
    endtask

    // Both requesters hold their request until the given number of grants has been seen.
    task automatic runBoth(input int n_gnts, input logic [15:0] addr);
        int seen = 0;
        int n = 0;
        driveReq(1'b0, 1'b0, addr, 16'h0000);
        driveReq(1'b1, 1'b0, addr, 16'h0000);
        while (seen < n_gnts && n < 100) begin
            @(negedge clk);
            n++;
            if (a_gnt || b_gnt) seen++;
        end
        if (seen < n_gnts) begin
            checks++;
            errors++;
            $display("[TB] FAIL both_gnt_timeout: got %0d grants expected %0d", seen, n_gnts);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        idle(4);
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected $finish before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gnt_cyc[4];
        int seen;
        int n;

        rst_n   = 1'b0;
        a_req   = 1'b1;
        a_we    = 1'b0;
        a_addr  = 16'h0004;
        a_wdata = 16'h0000;
        b_req   = 1'b0;
        b_we    = 1'b0;
        b_addr  = 16'h0000;
        b_wdata = 16'h0000;

        // A request held during reset must not be granted.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(3);
        a_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_a_rdata", a_rdata, 16'h0000);
        checkOutput("reset_b_rdata", b_rdata, 16'h0000);
        idle(1);

        $display("[TB] A write 0xBEEF to 0x0004, then read back");
        applyStimulus(1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF);

        $display("[TB] simultaneous requests after reset alternate A, B, A, B");
        doReset(2);
        pushTxn(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
        pushTxn(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
        pushTxn(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
        pushTxn(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
        runBoth(4, 16'h0004);

        $display("[TB] B out-of-range read of 0x0200");
        applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'hBEEF);

        $display("[TB] B write 0x1234 to odd address 0x0007, A reads 0x0006");
        applyStimulus(1'b1, 1'b1, 16'h0007, 16'h1234, 1'b0, 16'hBEEF);
        checkOutput("mem_word3", mem_model[3], 16'h1234);
        applyStimulus(1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h1234);

        $display("[TB] reset during ACCESS of A write 0x00FF to 0x0010");
        pushTxn(1'b0, 1'b1, 16'h0010, 16'h00FF, 1'b0, 16'h0000, 1'b0);
        driveReq(1'b0, 1'b1, 16'h0010, 16'h00FF);
        waitGnt(1'b0);
        @(posedge clk);
        #1;
        a_req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mem_word8_after_reset", mem_model[8], 16'h00FF);
        checkOutput("a_rdata_after_reset", a_rdata, 16'h0000);
        idle(1);
        pushTxn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00FF, 1'b1);
        pushTxn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00FF, 1'b1);
        runBoth(2, 16'h0010);

        $display("[TB] back-to-back A reads with a_req held");
        for (int i = 0; i < 4; i++) pushTxn(1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h1234, 1'b1);
        driveReq(1'b0, 1'b0, 16'h0006, 16'h0000);
        seen = 0;
        n = 0;
        while (seen < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (a_gnt) begin
                gnt_cyc[seen] = cyc;
                seen++;
            end
        end
        if (seen < 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL b2b_gnt_timeout: got %0d grants expected 4", seen);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checkOutput("b2b_gnt_spacing", 16'(gnt_cyc[i] - gnt_cyc[i-1]), 16'd2);
            end
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        idle(4);

        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
